seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, registered ALU for the EX stage with a valid/ready input handshake.
//  Single-cycle ops reuse the existing 5-bit ALUCtl encoding and produce a registered result 1 cycle after accept.
//  Adds iterative multi-cycle MULT/DIV that write HI/LO, with sign support.
//  Hazard unit stalls EX while busy is high.
// PARAMETERS
//  WIDTH    32               operand/result width; >=8, power of two
//  SHAMT_W  $clog2(WIDTH)    shift-amount bits taken from in1
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  in_valid     in   1       operation request
//  in_ready     out  1       1 = request accepted this edge
//  in1          in   WIDTH   operand A; dividend; shift amount
//  in2          in   WIDTH   operand B; divisor; shifted value
//  alu_ctl      in   5       operation select
//  sign         in   1       1 = signed SLT/MULT/DIV
//  out_valid    out  1       one-cycle pulse, result valid
//  out          out  WIDTH   result; LO for MULT/DIV
//  zero         out  1       (out == 0), registered with out
//  hi           out  WIDTH   MULT upper half / DIV remainder
//  lo           out  WIDTH   MULT lower half / DIV quotient
//  div0         out  1       divide-by-zero flag; valid with out_valid
//  busy         out  1       multi-cycle op in flight
// BEHAVIOUR
//  Codes: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00111 SLT (sign selects), 01100 NOR, 01101 XOR,
//   10000 SLL, 11000 SRL, 11001 SRA (shift in2 by in1[SHAMT_W-1:0]), 11010 MUL (low WIDTH bits),
//   11100 MULT, 11101 DIV. Any other code -> out = 0, single-cycle.
//  Reset (async, reset_n=0): state IDLE; all outputs 0 except in_ready=1.
//   Reset mid-operation aborts the op; no out_valid pulse is produced.
//  Accept: in_valid & in_ready at a rising edge (edge E0). in_ready = (state==IDLE).
//  Single-cycle op: out/zero are registered at E0; out_valid=1 for 1 cycle.
//   Back-to-back accepts are allowed every cycle. hi/lo are unchanged.
//  FSM: IDLE -> ITER on MULT/DIV accept; ITER -> FIX after WIDTH iterations; FIX -> IDLE.
//   Counter is loaded with WIDTH-1 at E0; edges E1..E_WIDTH each perform one step; the counter wraps at 0.
//   FIX edge E_(WIDTH+1): apply sign correction; register hi, lo, out=lo, zero, div0; out_valid=1 for 1 cycle.
//   Latency is WIDTH+1 cycles. busy=1 and in_ready=0 from after E0 through the FIX edge.
//  MULT: shift-add on |in1|,|in2| when sign=1, raw operands when sign=0.
//   2*WIDTH-bit product {hi,lo}; negated at FIX if sign=1 and the operand signs differ.
//  DIV: restoring division on magnitudes. Quotient truncates toward zero; remainder takes the dividend's sign.
//   Signed MIN / -1 -> lo=MIN, hi=0 (no trap).
//  Divisor == 0: full latency still applies; lo=all ones, hi=in1 (as supplied), div0=1.
//  in_valid while busy: ignored, not queued; the requester must hold it.
//  hi/lo hold until the next MULT/DIV completes; out holds until the next completion of any op.
//  Operands are latched at E0; input changes after E0 have no effect.
// TESTING
//  T1 reset: reset_n=0 mid-DIV at cycle 5 -> all outputs 0 immediately; no out_valid; in_ready=1 after release.
//  T2 single-cycle burst: ADD 7+5, SUB 3-3, SRA 4,0x80000000 on consecutive cycles ->
//     out 12/0/0xF8000000; zero=0/1/0; one out_valid per cycle.
//  T3 MULT sign=1: -3 * 0x7FFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x80000003; busy high for 33 cycles.
//  T4 DIV sign=1: -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
//     sign=0: 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1.
//  T5 DIV by zero: 100/0 -> lo=0xFFFFFFFF, hi=100, div0=1.
//     MIN/-1 signed -> lo=0x80000000, hi=0, div0=0.
//  T6 WIDTH=8 build: MULT 0xFF*0xFF sign=0 -> hi=0xFE, lo=0x01 after 9 cycles.
//     in_valid asserted during busy -> in_ready stays 0; no extra out_valid.

Source files
------------

// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle ops complete one edge after accept,
// MULT/DIV iterate one bit per cycle and then apply sign correction.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       alu_ctl,
  input  logic             sign,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0,
  output logic             busy
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b11000;
  localparam logic [4:0] OP_SRA  = 5'b11001;
  localparam logic [4:0] OP_MUL  = 5'b11010;
  localparam logic [4:0] OP_MULT = 5'b11100;
  localparam logic [4:0] OP_DIV  = 5'b11101;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 div0_q, div0_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     single_res;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div0      = div0_q;

  // Magnitudes only differ from the raw operands for signed MULT/DIV.
  assign a_neg = sign && in1[WIDTH-1];
  assign b_neg = sign && in2[WIDTH-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;
  assign shamt = in1[SHAMT_W-1:0];

  always_comb begin
    single_res = '0;
    case (alu_ctl)
      OP_AND: single_res = in1 & in2;
      OP_OR:  single_res = in1 | in2;
      OP_ADD: single_res = in1 + in2;
      OP_SUB: single_res = in1 - in2;
      OP_SLT: single_res = {{(WIDTH-1){1'b0}},
                            sign ? ($signed(in1) < $signed(in2)) : (in1 < in2)};
      OP_NOR: single_res = ~(in1 | in2);
      OP_XOR: single_res = in1 ^ in2;
      OP_SLL: single_res = in2 << shamt;
      OP_SRL: single_res = in2 >> shamt;
      OP_SRA: single_res = $signed(in2) >>> shamt;
      OP_MUL: single_res = in1 * in2;
      default: single_res = '0;
    endcase
  end

  // acc_lo holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first).
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_fix  = neg_q ? -prod : prod;
  assign quo_fix   = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    a_raw_d     = a_raw_q;
    out_d       = out_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    div0_d      = div0_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (alu_ctl == OP_MULT || alu_ctl == OP_DIV) begin
            state_d   = S_ITER;
            cnt_d     = SHAMT_W'(WIDTH - 1);
            is_div_d  = (alu_ctl == OP_DIV);
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = (in2 == '0);
            mcand_d   = b_mag;
            acc_hi_d  = '0;
            acc_lo_d  = a_mag;
            a_raw_d   = in1;
          end else begin
            out_d       = single_res;
            zero_d      = (single_res == '0);
            div0_d      = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        out_d       = lo_d;
        zero_d      = (lo_d == '0);
        div0_d      = is_div_q && dz_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      a_raw_q     <= '0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_q       <= neg_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      a_raw_q     <= a_raw_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div0_q      <= div0_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: 32-bit instance for the main ops, 8-bit instance
// for the narrow-width multiply and busy-time request handling.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid = 1'b0, sgn = 1'b0;
  logic [4:0]  ctl = '0;
  logic [31:0] a = '0, b = '0;
  logic        ready, ovalid, zero, div0, busy;
  logic [31:0] out, hi, lo;

  logic        valid8 = 1'b0, sgn8 = 1'b0;
  logic [4:0]  ctl8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, ovalid8, zero8, div08, busy8;
  logic [7:0]  out8, hi8, lo8;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(valid), .in_ready(ready),
    .in1(a), .in2(b), .alu_ctl(ctl), .sign(sgn), .out_valid(ovalid),
    .out(out), .zero(zero), .hi(hi), .lo(lo), .div0(div0), .busy(busy)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(valid8), .in_ready(ready8),
    .in1(a8), .in2(b8), .alu_ctl(ctl8), .sign(sgn8), .out_valid(ovalid8),
    .out(out8), .zero(zero8), .hi(hi8), .lo(lo8), .div0(div08), .busy(busy8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [4:0]  c;
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e_out;
    logic        e_zero;
  } vec_t;

  vec_t vecs[13];

  task automatic run_multi(input string nm, input logic [4:0] c, input logic s,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic ed0);
    int n, nb;
    bit seen;
    @(negedge clk);
    valid = 1'b1; ctl = c; sgn = s; a = x; b = y;
    #1 chk({nm, "_ready"}, ready, 1);
    @(posedge clk);
    #1;
    valid = 1'b0; a = ~x; b = ~y;
    nb = busy ? 1 : 0;
    n = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (ovalid) seen = 1;
      else if (busy) nb++;
    end
    chk({nm, "_latency"}, n, 33);
    chk({nm, "_busy_cycles"}, nb, 33);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    chk({nm, "_out"}, out, elo);
    chk({nm, "_div0"}, div0, ed0);
    chk({nm, "_zero"}, zero, (elo == 0));
    $display("MULTI %s hi=0x%08h lo=0x%08h div0=%0d cycles=%0d", nm, hi, lo, div0, n);
    @(posedge clk);
    #1 chk({nm, "_pulse_end"}, ovalid, 0);
  endtask

  initial begin
    int n, pulses, rdy_bad;
    bit seen;

    vecs[0]  = '{"add",      5'b00010, 1'b0, 32'd7,        32'd5,        32'd12,        1'b0};
    vecs[1]  = '{"sub",      5'b00110, 1'b0, 32'd3,        32'd3,        32'd0,         1'b1};
    vecs[2]  = '{"sra",      5'b11001, 1'b0, 32'd4,        32'h80000000, 32'hF8000000,  1'b0};
    vecs[3]  = '{"and",      5'b00000, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000,  1'b0};
    vecs[4]  = '{"or",       5'b00001, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0,  1'b0};
    vecs[5]  = '{"slt_s",    5'b00111, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd1,         1'b0};
    vecs[6]  = '{"slt_u",    5'b00111, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,         1'b1};
    vecs[7]  = '{"nor",      5'b01100, 1'b0, 32'd0,        32'd0,        32'hFFFFFFFF,  1'b0};
    vecs[8]  = '{"xor",      5'b01101, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0,  1'b0};
    vecs[9]  = '{"sll",      5'b10000, 1'b0, 32'd4,        32'd1,        32'h00000010,  1'b0};
    vecs[10] = '{"srl",      5'b11000, 1'b0, 32'd4,        32'h80000000, 32'h08000000,  1'b0};
    vecs[11] = '{"mul",      5'b11010, 1'b0, 32'h00010000, 32'h00010003, 32'h00030000,  1'b0};
    vecs[12] = '{"undef",    5'b00011, 1'b0, 32'd9,        32'd9,        32'd0,         1'b1};

    // Reset state
    #3;
    chk("rst_ready", ready, 1);
    chk("rst_valid", ovalid, 0);
    chk("rst_out", out, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero", zero, 0);
    chk("rst_div0", div0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back single-cycle ops
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      valid = 1'b1; ctl = vecs[i].c; sgn = vecs[i].s; a = vecs[i].x; b = vecs[i].y;
      #1 chk({vecs[i].nm, "_ready"}, ready, 1);
      @(posedge clk);
      #1;
      chk({vecs[i].nm, "_valid"}, ovalid, 1);
      chk({vecs[i].nm, "_out"}, out, vecs[i].e_out);
      chk({vecs[i].nm, "_zero"}, zero, vecs[i].e_zero);
      $display("SINGLE %s out=0x%08h zero=%0d", vecs[i].nm, out, zero);
    end
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1 chk("single_no_extra_valid", ovalid, 0);

    run_multi("mult_s", 5'b11100, 1'b1, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h80000003, 1'b0);

    // Single-cycle op must leave hi/lo alone
    @(negedge clk);
    valid = 1'b1; ctl = 5'b00010; sgn = 1'b0; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("hold_out", out, 2);
    chk("hold_hi", hi, 32'hFFFFFFFE);
    chk("hold_lo", lo, 32'h80000003);

    run_multi("div_s",    5'b11101, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_multi("div_u",    5'b11101, 1'b0, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 1'b0);
    run_multi("mult_u",   5'b11100, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_multi("div_zero", 5'b11101, 1'b0, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
    run_multi("div_min",  5'b11101, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);

    // Reset during a DIV aborts it
    @(negedge clk);
    valid = 1'b1; ctl = 5'b11101; sgn = 1'b1; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_out", out, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", ovalid, 0);
    chk("abort_ready", ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (ovalid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_ready_after", ready, 1);
    $display("ABORT pulses=%0d ready=%0d", pulses, ready);

    // 8-bit MULT with in_valid held through busy
    @(negedge clk);
    valid8 = 1'b1; ctl8 = 5'b11100; sgn8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    n = 0; pulses = 0; rdy_bad = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ready8) rdy_bad++;
      @(posedge clk);
      #1;
      n++;
      if (ovalid8) begin
        pulses++;
        seen = 1;
      end
    end
    valid8 = 1'b0;
    chk("w8_latency", n, 9);
    chk("w8_ready_low", rdy_bad, 0);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (ovalid8) pulses++;
    end
    chk("w8_one_pulse", pulses, 1);
    $display("W8 hi=0x%02h lo=0x%02h cycles=%0d pulses=%0d", hi8, lo8, n, pulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
